div_reconstruct: RTL and testbench

- Inverse-direction companion to the repeated-subtraction divider.
- Takes a (quotient, divisor, remainder) triple and rebuilds the dividend as quotient*divisor + remainder.
- Uses repeated addition, split into a controller FSM and a datapath. Start/done handshake matches the divider's.
- Used as a self-check stage after the divider (loopback) and as a standalone multiply-accumulate.

---
 rtl/div_reconstruct.sv | 141 ++++++++++++++
 tb/tb_div_reconstruct.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/div_reconstruct.sv
// Rebuilds a dividend from (quotient, divisor, remainder) as Q*D+R by repeated
// addition; controller FSM and datapath share a start/done handshake with the divider.
module div_reconstruct #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     remainder,
    output logic [2*WIDTH-1:0]   dividend,
    output logic                 rem_ok,
    output logic                 ovf,
    output logic                 busy,
    output logic                 done
);

    localparam int W2 = 2 * WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_reg_q, d_reg_d;
    logic [WIDTH-1:0] r_reg_q, r_reg_d;
    logic [W2-1:0]    dividend_q, dividend_d;
    logic             rem_ok_q, rem_ok_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_zero_s;

    assign cnt_zero_s = (cnt_q == {WIDTH{1'b0}});

    // Controller: next-state decode; start only matters in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD:  state_d = S_CHECK;
            S_CHECK: begin
                if (cnt_zero_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_ADD:   state_d = S_CHECK;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand latch, accumulate, and result capture on the CHECK->DONE edge
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        d_reg_d    = d_reg_q;
        r_reg_d    = r_reg_q;
        dividend_d = dividend_q;
        rem_ok_d   = rem_ok_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_LOAD: begin
                acc_d   = {{WIDTH{1'b0}}, remainder};
                cnt_d   = quotient;
                d_reg_d = divisor;
                r_reg_d = remainder;
            end
            S_CHECK: begin
                if (cnt_zero_s) begin
                    dividend_d = acc_q;
                    rem_ok_d   = (r_reg_q < d_reg_q);
                    ovf_d      = (acc_q[W2-1:WIDTH] != {WIDTH{1'b0}});
                end else begin
                    dividend_d = dividend_q;
                end
            end
            // Accumulator is 2*WIDTH wide, so Q*D+R can never wrap
            S_ADD: begin
                acc_d = acc_q + {{WIDTH{1'b0}}, d_reg_q};
                cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Status flags are registered from the next state so they track state_q exactly
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= {W2{1'b0}};
            cnt_q      <= {WIDTH{1'b0}};
            d_reg_q    <= {WIDTH{1'b0}};
            r_reg_q    <= {WIDTH{1'b0}};
            dividend_q <= {W2{1'b0}};
            rem_ok_q   <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            d_reg_q    <= d_reg_d;
            r_reg_q    <= r_reg_d;
            dividend_q <= dividend_d;
            rem_ok_q   <= rem_ok_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dividend = dividend_q;
    assign rem_ok   = rem_ok_q;
    assign ovf      = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_div_reconstruct.sv
// Self-checking bench for div_reconstruct: directed corner cases plus random
// operands compared against plain Q*D+R arithmetic.
module tb_div_reconstruct;

    localparam int WIDTH  = 8;
    localparam int BUDGET = 600;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     remainder;
    logic [2*WIDTH-1:0]   dividend;
    logic                 rem_ok;
    logic                 ovf;
    logic                 busy;
    logic                 done;

    int tests = 0;
    int fails = 0;

    div_reconstruct #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .dividend  (dividend),
        .rem_ok    (rem_ok),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts negedges after the start-sampling edge until done; dividend must hold meanwhile.
    task automatic wait_done(input bit held, input int dist_at,
                             output int n, output int busy_n);
        logic [2*WIDTH-1:0] prev;
        prev   = dividend;
        n      = 0;
        busy_n = 0;
        while (n < BUDGET) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (!held && n == 1) start = 1'b0;
            if (n == dist_at) begin
                quotient  = 8'($urandom);
                divisor   = 8'($urandom);
                remainder = 8'($urandom);
                start     = 1'b1;
            end else if (n == dist_at + 1) begin
                start = 1'b0;
            end
            if (done) break;
            check("dividend_hold", 32'(dividend), 32'(prev));
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    // Launch one operation from a negedge in IDLE and check it against Q*D+R.
    task automatic run_op(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                          input bit held, input int dist_at);
        int n, busy_n, exp_val;
        quotient  = q;
        divisor   = d;
        remainder = r;
        start     = 1'b1;
        exp_val   = int'(q) * int'(d) + int'(r);
        wait_done(held, dist_at, n, busy_n);
        check("latency", 32'(n), 32'(2 * int'(q) + 3));
        check("busy_cycles", 32'(busy_n), 32'(2 * int'(q) + 3));
        check("dividend", 32'(dividend), 32'(exp_val));
        check("rem_ok", 32'(rem_ok), 32'(r < d));
        check("ovf", 32'(ovf), 32'(exp_val > 255));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("idle_gap", 32'(busy), 32'd0);
    endtask

    initial begin
        int extra;
        rst       = 1'b1;
        start     = 1'b0;
        quotient  = 8'd0;
        divisor   = 8'd0;
        remainder = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_dividend", 32'(dividend), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'({rem_ok, ovf}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'd5, 8'd3, 8'd2, 1'b0, 0);
        run_op(8'd0, 8'd9, 8'd4, 1'b0, 0);
        run_op(8'd9, 8'd0, 8'd7, 1'b0, 0);
        run_op(8'd255, 8'd255, 8'd254, 1'b0, 0);
        run_op(8'd28, 8'd7, 8'd4, 1'b0, 0);

        // Inputs scrambled and start re-pulsed while the Q=4 run is in ADD
        run_op(8'd4, 8'd6, 8'd1, 1'b0, 5);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        check("no_second_op", 32'(extra), 32'd0);

        // Reset mid-ADD aborts with no done and clears the result
        quotient  = 8'd10;
        divisor   = 8'd3;
        remainder = 8'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dividend", 32'(dividend), 32'd0);
        check("abort_flags", 32'({rem_ok, ovf}), 32'd0);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        check("abort_quiet", 32'(extra), 32'd0);
        run_op(8'd2, 8'd2, 8'd1, 1'b0, 0);

        // start held high: back-to-back operations with one IDLE cycle between
        run_op(8'd3, 8'd4, 8'd1, 1'b1, 0);
        run_op(8'd6, 8'd200, 8'd250, 1'b1, 0);
        run_op(8'd1, 8'd17, 8'd16, 1'b1, 0);
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(8'($urandom_range(0, 30)), 8'($urandom), 8'($urandom), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
